// File: rtl/load_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_pkg
// Description : Shared definitions for the RISC-V load unit: funct3 codes,
//               FSM state encoding, width/sign decode and alignment check.
// Revision    : 1.0 - initial release
// ============================================================================
package load_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_REQ   = 3'd2,
        S_WB    = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_t;

    // Access width is encoded directly in funct3[1:0]
    function automatic size_t f3_size(input logic [2:0] f3);
        return size_t'(f3[1:0]);
    endfunction

    // funct3[2] set means zero-extend (LBU/LHU/LWU)
    function automatic logic f3_signed(input logic [2:0] f3);
        return ~f3[2];
    endfunction

    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3 == 3'b111);
    endfunction

    // True when the byte lane is not naturally aligned for the access width
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] lane);
        logic bad;
        case (f3_size(f3))
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lane[0];
            SZ_W:    bad = |lane[1:0];
            default: bad = |lane;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_extract.sv
`default_nettype none
// ============================================================================
// Module      : load_extract
// Description : Combinational lane shift, width select and sign/zero
//               extension of a returned memory doubleword.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extract
    import load_pkg::*;
#(
    parameter int WORDSIZE = 64
) (
    input  logic [WORDSIZE-1:0] mem_rdata,
    input  logic [2:0]          lane,
    input  logic [2:0]          funct3,
    output logic [WORDSIZE-1:0] result
);

    logic [WORDSIZE-1:0] shifted;
    logic                sgn;

    // Move the addressed byte lane to bit 0, then trim and extend to full width
    always_comb begin
        shifted = mem_rdata >> {lane, 3'b000};
        sgn     = f3_signed(funct3);
        result  = shifted;
        case (f3_size(funct3))
            SZ_B:    result = {{(WORDSIZE-8){sgn & shifted[7]}},   shifted[7:0]};
            SZ_H:    result = {{(WORDSIZE-16){sgn & shifted[15]}}, shifted[15:0]};
            SZ_W:    result = {{(WORDSIZE-32){sgn & shifted[31]}}, shifted[31:0]};
            default: result = shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_unit
// Description : Executes decoded RISC-V loads: effective address, one memory
//               read, lane extraction and a single-cycle register write-back.
//               Optional REQ-phase timeout enabled by LOAD_UNIT_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module load_unit
    import load_pkg::*;
#(
    parameter int WORDSIZE = 64,
    parameter int ADDRSIZE = 64,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                ready,
    input  logic [11:0]         immediate,
    input  logic [WORDSIZE-1:0] rs1_value,
    input  logic [2:0]          funct3,
    input  logic [4:0]          rd,
    output logic                mem_req,
    output logic [ADDRSIZE-1:0] mem_addr,
    input  logic                mem_ack,
    input  logic [WORDSIZE-1:0] mem_rdata,
    output logic                wb_en,
    output logic [4:0]          wb_rd,
    output logic [WORDSIZE-1:0] wb_data,
    output logic                fault
);

    state_t              state;
    state_t              state_next;
    logic [11:0]         imm_q;
    logic [WORDSIZE-1:0] rs1_q;
    logic [2:0]          f3_q;
    logic [4:0]          rd_q;
    logic [ADDRSIZE-1:0] ea;
    logic [WORDSIZE-1:0] extracted;
    logic                timed_out;

    // Latched fields are stable from CHECK onward, so the address needs no register
    assign ea    = ADDRSIZE'(rs1_q) + {{(ADDRSIZE-12){imm_q[11]}}, imm_q};
    assign wb_rd = rd_q;

    load_extract #(
        .WORDSIZE (WORDSIZE)
    ) u_extract (
        .mem_rdata (mem_rdata),
        .lane      (ea[2:0]),
        .funct3    (f3_q),
        .result    (extracted)
    );

`ifdef LOAD_UNIT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Count REQ cycles without an acknowledge; cleared while passing through CHECK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == S_CHECK) begin
            wait_cnt <= '0;
        end else if (state == S_REQ && !mem_ack) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Terminal REQ cycle: this is the TIMEOUT-th cycle spent waiting
    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-state outputs; an ack coinciding with timeout completes the load
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        wb_en      = 1'b0;
        fault      = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_next = S_CHECK;
            end
            S_CHECK: begin
                if (f3_illegal(f3_q) || is_misaligned(f3_q, ea[2:0])) state_next = S_ERR;
                else                                                   state_next = S_REQ;
            end
            S_REQ: begin
                mem_req  = 1'b1;
                mem_addr = {ea[ADDRSIZE-1:3], 3'b000};
                if (mem_ack)        state_next = S_WB;
                else if (timed_out) state_next = S_ERR;
            end
            S_WB: begin
                wb_en      = (rd_q != 5'd0);
                state_next = S_IDLE;
            end
            S_ERR: begin
                fault      = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Capture request fields on acceptance and the load result on acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_q   <= '0;
            rs1_q   <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            wb_data <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                imm_q <= immediate;
                rs1_q <= rs1_value;
                f3_q  <= funct3;
                rd_q  <= rd;
            end
            if (state == S_REQ && mem_ack) begin
                wb_data <= extracted;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_unit
// Description : Directed self-checking bench for load_unit. Timeout scenario
//               is included when LOAD_UNIT_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        ready;
    logic [11:0] immediate;
    logic [63:0] rs1_value;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        fault;

    int checks   = 0;
    int failures = 0;

    load_unit #(
        .WORDSIZE (64),
        .ADDRSIZE (64),
        .TIMEOUT  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ready     (ready),
        .immediate (immediate),
        .rs1_value (rs1_value),
        .funct3    (funct3),
        .rd        (rd),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns one cycle after the accepting edge
    task automatic issue(input logic [2:0] f3, input logic [63:0] rs1,
                         input logic [11:0] imm, input logic [4:0] rdi);
        start     = 1'b1;
        funct3    = f3;
        rs1_value = rs1;
        immediate = imm;
        rd        = rdi;
        step();
        start = 1'b0;
    endtask

    // Full load with acknowledge on the first REQ cycle
    task automatic run_load(input string tag, input logic [2:0] f3, input logic [63:0] rs1,
                            input logic [11:0] imm, input logic [4:0] rdi,
                            input logic [63:0] rdata, input logic [63:0] exp_addr,
                            input logic [63:0] exp_data);
        issue(f3, rs1, imm, rdi);
        check({tag, "_check_ready"}, {63'd0, ready}, 64'd0);
        check({tag, "_check_req"},   {63'd0, mem_req}, 64'd0);
        step();
        check({tag, "_req"},  {63'd0, mem_req}, 64'd1);
        check({tag, "_addr"}, mem_addr, exp_addr);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 64'd0;
        check({tag, "_wb_en"},   {63'd0, wb_en}, {63'd0, (rdi != 5'd0)});
        check({tag, "_wb_rd"},   {59'd0, wb_rd}, {59'd0, rdi});
        check({tag, "_wb_data"}, wb_data, exp_data);
        check({tag, "_wb_fault"}, {63'd0, fault}, 64'd0);
        check({tag, "_wb_req"},  {63'd0, mem_req}, 64'd0);
        step();
        check({tag, "_idle_wb_en"}, {63'd0, wb_en}, 64'd0);
        check({tag, "_idle_ready"}, {63'd0, ready}, 64'd1);
        check({tag, "_hold_data"},  wb_data, exp_data);
    endtask

    // Rejected load: one ERR cycle, no memory request, no write-back
    task automatic run_fault(input string tag, input logic [2:0] f3,
                             input logic [63:0] rs1, input logic [11:0] imm);
        issue(f3, rs1, imm, 5'd3);
        check({tag, "_check_req"},   {63'd0, mem_req}, 64'd0);
        check({tag, "_check_fault"}, {63'd0, fault}, 64'd0);
        step();
        check({tag, "_err_fault"}, {63'd0, fault}, 64'd1);
        check({tag, "_err_req"},   {63'd0, mem_req}, 64'd0);
        check({tag, "_err_wb_en"}, {63'd0, wb_en}, 64'd0);
        check({tag, "_err_ready"}, {63'd0, ready}, 64'd0);
        step();
        check({tag, "_after_fault"}, {63'd0, fault}, 64'd0);
        check({tag, "_after_ready"}, {63'd0, ready}, 64'd1);
        check({tag, "_after_req"},   {63'd0, mem_req}, 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        immediate = 12'd0;
        rs1_value = 64'd0;
        funct3    = 3'd0;
        rd        = 5'd0;
        mem_ack   = 1'b0;
        mem_rdata = 64'd0;

        #12;
        check("rst_ready",   {63'd0, ready},   64'd1);
        check("rst_mem_req", {63'd0, mem_req}, 64'd0);
        check("rst_addr",    mem_addr,         64'd0);
        check("rst_wb_en",   {63'd0, wb_en},   64'd0);
        check("rst_wb_rd",   {59'd0, wb_rd},   64'd0);
        check("rst_wb_data", wb_data,          64'd0);
        check("rst_fault",   {63'd0, fault},   64'd0);
        rst_n = 1'b1;
        step();

        run_load("ld",   3'b011, 64'h1000, 12'h008, 5'd5, 64'h1122334455667788,
                 64'h1008, 64'h1122334455667788);
        run_load("lb",   3'b000, 64'h2003, 12'h000, 5'd6, 64'h1122334480667788,
                 64'h2000, 64'hFFFFFFFFFFFFFF80);
        run_load("lbu",  3'b100, 64'h2003, 12'h000, 5'd6, 64'h1122334480667788,
                 64'h2000, 64'h0000000000000080);
        run_load("lh",   3'b001, 64'h4006, 12'h000, 5'd7, 64'h8001000000000000,
                 64'h4000, 64'hFFFFFFFFFFFF8001);
        run_load("lhu",  3'b101, 64'h4006, 12'h000, 5'd7, 64'h8001000000000000,
                 64'h4000, 64'h0000000000008001);
        run_load("lw",   3'b010, 64'h5004, 12'h000, 5'd8, 64'hDEADBEEF12345678,
                 64'h5000, 64'hFFFFFFFFDEADBEEF);
        run_load("lwu",  3'b110, 64'h5004, 12'h000, 5'd8, 64'hDEADBEEF12345678,
                 64'h5000, 64'h00000000DEADBEEF);
        run_load("wrap", 3'b000, 64'h0,    12'hFFF, 5'd9, 64'h8500000000000000,
                 64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFF85);
        run_load("negimm", 3'b011, 64'h1010, 12'hFF8, 5'd31, 64'h0123456789ABCDEF,
                 64'h1008, 64'h0123456789ABCDEF);
        run_load("rd0",  3'b011, 64'h1000, 12'h000, 5'd0, 64'hCAFEF00DCAFEF00D,
                 64'h1000, 64'hCAFEF00DCAFEF00D);

        run_fault("mis_lw",  3'b010, 64'h3002, 12'h000);
        run_fault("illegal", 3'b111, 64'h3000, 12'h000);
        run_fault("mis_ld",  3'b011, 64'h1004, 12'h000);
        run_fault("mis_lh",  3'b001, 64'h1001, 12'h000);

        // start while busy must not replace the transaction in flight
        issue(3'b011, 64'h8000, 12'h000, 5'd10);
        step();
        start     = 1'b1;
        rs1_value = 64'h9000;
        rd        = 5'd11;
        step();
        start = 1'b0;
        check("busy_addr", mem_addr, 64'h8000);
        mem_ack   = 1'b1;
        mem_rdata = 64'h5555;
        step();
        mem_ack = 1'b0;
        check("busy_wb_rd", {59'd0, wb_rd}, 64'd10);
        step();
        check("busy_ready", {63'd0, ready}, 64'd1);
        step();
        check("busy_no_new_req", {63'd0, mem_req}, 64'd0);

        // acknowledge while idle is ignored
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("idle_ack_wb_en", {63'd0, wb_en}, 64'd0);
        check("idle_ack_ready", {63'd0, ready}, 64'd1);

        // asynchronous reset in the middle of a delayed REQ
        issue(3'b011, 64'h6000, 12'h000, 5'd12);
        step();
        check("abort_req", {63'd0, mem_req}, 64'd1);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_mem_req", {63'd0, mem_req}, 64'd0);
        check("abort_ready",   {63'd0, ready},   64'd1);
        check("abort_addr",    mem_addr,         64'd0);
        check("abort_wb_data", wb_data,          64'd0);
        check("abort_wb_rd",   {59'd0, wb_rd},   64'd0);
        #2;
        rst_n     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 64'h7777;
        step();
        mem_ack = 1'b0;
        check("late_ack_wb_en", {63'd0, wb_en},   64'd0);
        check("late_ack_req",   {63'd0, mem_req}, 64'd0);
        step();
        check("late_ack_wb_en2", {63'd0, wb_en}, 64'd0);
        check("late_ack_data",   wb_data,        64'd0);

`ifdef LOAD_UNIT_TIMEOUT_EN
        // no acknowledge: four REQ cycles, then a fault pulse
        issue(3'b011, 64'h7000, 12'h000, 5'd13);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("tmo_req_%0d", i), {63'd0, mem_req}, 64'd1);
        end
        step();
        check("tmo_req_drop", {63'd0, mem_req}, 64'd0);
        check("tmo_fault",    {63'd0, fault},   64'd1);
        check("tmo_wb_en",    {63'd0, wb_en},   64'd0);
        step();
        check("tmo_ready",       {63'd0, ready}, 64'd1);
        check("tmo_fault_clear", {63'd0, fault}, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_unit.md
Name: load_unit

Overview:
Executes decoded RISC-V load instructions and sits directly downstream of the I-type field decoder.
- Consumes immediate, funct3 and rd from the decoder, plus the rs1 register value from the register file.
- Computes the effective address and runs one read transaction on the data-memory port.
- Aligns and extends the returned data, then presents a single-cycle register-file write-back.

Parameters:
WORDSIZE, 64, data/register width in bits (fixed 64; byte lanes assume 8 bytes)
ADDRSIZE, 64, memory address width in bits
TIMEOUT, 255, max cycles waiting for mem_ack (used only with LOAD_UNIT_TIMEOUT_EN)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset; asynchronous, active-low
start  input  1  request: load fields valid this cycle
ready  output  1  high in IDLE; start is accepted only when ready=1
immediate  input  12  I-type immediate, signed
rs1_value  input  WORDSIZE  base register value
funct3  input  3  load width/sign selector
rd  input  5  destination register index
mem_req  output  1  read request, held until mem_ack
mem_addr  output  ADDRSIZE  doubleword-aligned address (effective address with [2:0] cleared)
mem_ack  input  1  read data valid on mem_rdata this cycle
mem_rdata  input  WORDSIZE  aligned 64-bit doubleword
wb_en  output  1  one-cycle write-back strobe
wb_rd  output  5  write-back register index
wb_data  output  WORDSIZE  extended load result
fault  output  1  one-cycle pulse: illegal funct3, misaligned access or timeout

Behaviour:
- Reset (async, rst_n=0): state IDLE; ready=1; mem_req=0; mem_addr=0; wb_en=0; wb_rd=0; wb_data=0; fault=0; all latched fields cleared.
- Reset mid-transaction aborts immediately. A pending mem_ack after reset is ignored.
- Acceptance: start & ready at edge N latches immediate, rs1_value, funct3, rd. start while not ready is ignored.
- Effective address: ea = rs1_value + sign_extend(immediate) to ADDRSIZE, modulo 2^ADDRSIZE. Wrap-around is silent.
- funct3 encoding:
  - 000 LB; 001 LH; 010 LW; 011 LD; 100 LBU; 101 LHU; 110 LWU.
  - 111 is illegal.
- Alignment rules: LH/LHU need ea[0]=0; LW/LWU need ea[1:0]=0; LD needs ea[2:0]=0. Byte loads are never misaligned.
- FSM states: IDLE, CHECK, REQ, WB, ERR.
  - IDLE -> CHECK on accepted start.
  - CHECK (1 cycle): compute ea. Illegal funct3 or misaligned -> ERR; otherwise -> REQ.
  - REQ: mem_req=1, mem_addr={ea[ADDRSIZE-1:3],3'b000}, both held stable. On mem_ack: capture the extracted result -> WB.
  - WB (1 cycle): wb_en=1 unless rd==0, in which case wb_en=0 and there is no fault; wb_rd=rd; wb_data valid. Then -> IDLE.
  - ERR (1 cycle): fault=1, no memory request issued, wb_en=0. Then -> IDLE.
- Extraction: lane = ea[2:0]; field = mem_rdata >> (8*lane), truncated to width. Signed ops sign-extend, unsigned ops zero-extend to WORDSIZE.
- Latency: start at edge N, mem_req high from N+2, mem_ack at edge K, wb_en high in cycle K+1. With mem_ack at the first REQ cycle, the minimum is 4 cycles from start to the end of WB.
- ready=0 in every state except IDLE. wb_data holds its last value outside WB.
- mem_ack outside REQ is ignored.

Optional Feature:
LOAD_UNIT_TIMEOUT_EN
- Defined: a counter clears on entry to REQ and increments each REQ cycle without mem_ack. When it reaches TIMEOUT: mem_req drops, -> ERR, fault pulses. mem_ack in the same cycle as the terminal count wins, so the load completes normally.
- Undefined: no counter; REQ waits indefinitely for mem_ack.

Decomposition:
- Package load_pkg holds:
  - funct3 localparams (F3_LB..F3_LWU);
  - the FSM state enum;
  - an is_signed/width-decode function;
  - the misalignment-check function.
- Sub-module load_extract: combinational shift by lane, width select and sign/zero extension. Inputs mem_rdata, lane, funct3; output the WORDSIZE result.

Test Plan:
- LD, rs1=0x1000, imm=0x008, mem_rdata=0x1122334455667788, ack first REQ cycle -> mem_addr=0x1008, wb_data=0x1122334455667788, wb_en one cycle, 4 cycles start-to-WB end.
- LB vs LBU, rs1=0x2003, imm=0, mem_rdata byte3=0x80 -> mem_addr=0x2000; LB wb_data=0xFFFFFFFFFFFFFF80; LBU 0x0000000000000080.
- LW, rs1=0x3002, imm=0 -> fault pulse, mem_req never asserted, wb_en=0. funct3=111 -> same response.
- Negative immediate: rs1=0x0, imm=0xFFF, LB -> ea wraps to 0xFFFFFFFFFFFFFFFF, mem_addr=0xFFFFFFFFFFFFFFF8, lane 7 extracted.
- rst_n low during REQ with ack delayed 5 cycles -> all outputs reset immediately; a late mem_ack produces no wb_en; rd=0 load completes with wb_en=0.
- With LOAD_UNIT_TIMEOUT_EN and TIMEOUT=4, mem_ack never asserted -> mem_req drops after 4 REQ cycles, fault pulses, ready returns to 1.
